// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_SYM_W   = 2;
  localparam int unsigned DEF_SEQ_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Control, stream and status bundle between the switch front end and the detector.
interface seq_det_param_if
  import seq_det_pkg::*;
#(
  parameter int unsigned SYM_W = DEF_SYM_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             det_en;
  logic             overlap;
  logic             pat_clr;
  logic             pat_wr;
  logic [SYM_W-1:0] pat_sym;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             cnt_clr;
  logic             pat_ready;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output det_en, overlap, pat_clr, pat_wr, pat_sym, in_valid, in_sym, cnt_clr,
    input  pat_ready, match, match_cnt
  );

  modport slave (
    input  det_en, overlap, pat_clr, pat_wr, pat_sym, in_valid, in_sym, cnt_clr,
    output pat_ready, match, match_cnt
  );
endinterface

// File: rtl/seq_hist_shift.sv
// Symbol history shift register with fill tracking and post-shift pattern compare.
module seq_hist_shift
  import seq_det_pkg::*;
#(
  parameter int unsigned SYM_W   = DEF_SYM_W,
  parameter int unsigned SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift,
  input  logic                     flush,
  input  logic                     overlap,
  input  logic [SYM_W-1:0]         sym,
  input  logic [SYM_W*SEQ_LEN-1:0] pattern,
  output logic                     hit_c
);
  localparam int unsigned VEC_W  = SYM_W * SEQ_LEN;
  localparam int unsigned FILL_W = clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

  logic [VEC_W-1:0]  hist_q;
  logic [VEC_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_inc;

  // Newest symbol enters the top slot; slot 0 holds the oldest, matching pattern index 0.
  always_comb begin
    hist_nxt = {sym, hist_q[VEC_W-1:SYM_W]};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
    hit_c    = shift && (fill_inc == FULL) && (hist_nxt == pattern);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (flush) begin
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist_nxt;
      fill_q <= (hit_c && !overlap) ? '0 : fill_inc;
    end
  end
endmodule

// File: rtl/seq_det_param.sv
// Programmable-pattern sequence detector: pattern load, accept gating, match pulse and counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned SYM_W   = DEF_SYM_W,
  parameter int unsigned SEQ_LEN = DEF_SEQ_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  seq_det_param_if.slave bus
);
  localparam int unsigned VEC_W  = SYM_W * SEQ_LEN;
  localparam int unsigned PCNT_W = clog2(SEQ_LEN + 1);
  localparam logic [PCNT_W-1:0] FULL = PCNT_W'(SEQ_LEN);

  logic [VEC_W-1:0]  pat_q;
  logic [PCNT_W-1:0] pat_cnt_q;
  logic              pat_ready_q;
  logic              match_q;
  logic [CNT_W-1:0]  match_cnt_q;
  logic              accept_c;
  logic              wr_ok_c;
  logic              flush_c;
  logic              hit_c;

  // Pattern writes and clears take priority over stream symbols in the same cycle.
  always_comb begin
    accept_c = bus.in_valid && bus.det_en && pat_ready_q && !bus.pat_clr && !bus.pat_wr;
    wr_ok_c  = bus.pat_wr && !bus.pat_clr && (pat_cnt_q != FULL);
    flush_c  = bus.pat_clr || wr_ok_c || !bus.det_en;
  end

  seq_hist_shift #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .shift   (accept_c),
    .flush   (flush_c),
    .overlap (bus.overlap),
    .sym     (bus.in_sym),
    .pattern (pat_q),
    .hit_c   (hit_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= '0;
      pat_cnt_q   <= '0;
      pat_ready_q <= 1'b0;
    end else if (bus.pat_clr) begin
      pat_q       <= '0;
      pat_cnt_q   <= '0;
      pat_ready_q <= 1'b0;
    end else if (wr_ok_c) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
        if (pat_cnt_q == PCNT_W'(i)) pat_q[i*SYM_W +: SYM_W] <= bus.pat_sym;
      end
      pat_cnt_q   <= pat_cnt_q + PCNT_W'(1);
      pat_ready_q <= ((pat_cnt_q + PCNT_W'(1)) == FULL);
    end
  end

  // Counter clear beats a coincident hit; the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      match_q <= hit_c;
      if (bus.cnt_clr) begin
        match_cnt_q <= '0;
      end else if (hit_c && (match_cnt_q != '1)) begin
        match_cnt_q <= match_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pat_ready = pat_ready_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised successor to the fixed 4-bit DIP-switch sequence detector.
- Detects a run-time-programmable pattern of SEQ_LEN symbols, each SYM_W bits, on a valid-qualified input stream.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits between the key_control debounce outputs and the seq_control 7-segment display path; match_cnt drives the display digits.

Parameters:
- SYM_W, 2, width of one symbol in bits (1..8)
- SEQ_LEN, 4, pattern length in symbols (2..16)
- CNT_W, 8, width of the match counter in bits

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous reset, active-high
- det_en  input  1  detection enable; low clears history and suppresses matches
- overlap  input  1  1 = overlapping matches allowed, 0 = history flushed after each match
- pat_clr  input  1  clear stored pattern and history
- pat_wr  input  1  append pat_sym to pattern
- pat_sym  input  SYM_W  pattern symbol
- in_valid  input  1  in_sym valid this cycle
- in_sym  input  SYM_W  stream symbol
- cnt_clr  input  1  clear match counter
- pat_ready  output  1  pattern holds SEQ_LEN symbols
- match  output  1  one-cycle match pulse
- match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset (rst=1 at posedge) values:
  - pattern store and pat_cnt = 0; pat_ready = 0
  - history shift register and fill = 0
  - match = 0; match_cnt = 0
- Pattern load:
  - pat_wr writes pat_sym at index pat_cnt (index 0 = first symbol expected), then pat_cnt++.
  - pat_wr is ignored when pat_cnt == SEQ_LEN.
  - Every accepted pat_wr clears history fill.
  - pat_ready = (pat_cnt == SEQ_LEN), registered.
  - pat_clr zeroes pat_cnt, fill and pattern contents; match_cnt is kept.
  - pat_clr and pat_wr in the same cycle: pat_clr wins and pat_wr is dropped.
- Accept condition: a symbol is accepted when in_valid && det_en && pat_ready && !pat_clr && !pat_wr.
  - Otherwise in_sym is ignored and history is unchanged.
  - Exception: det_en=0 sets fill to 0 every cycle.
- History:
  - On accept, shift in_sym into the newest slot and fill = min(fill+1, SEQ_LEN).
  - Compare is on the post-shift value: the SEQ_LEN newest symbols, oldest first, must equal the pattern, and the new fill must equal SEQ_LEN.
- Match timing:
  - On compare hit, match=1 in the cycle after the accepting edge (1-cycle latency, registered).
  - match is 0 in every other cycle.
  - Back-to-back hits in overlap mode give consecutive 1s.
- Overlap mode:
  - overlap=1: history is kept after a hit, so a suffix of the pattern can start the next match.
  - overlap=0: fill is set to 0 on the hit edge, so the next match needs SEQ_LEN fresh symbols.
  - overlap is sampled on the accepting edge.
- Counter:
  - match_cnt++ on each hit edge (same edge that sets match); saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr zeroes it.
  - cnt_clr together with a hit: result is 0.
- Mid-operation reset: rst overrides all inputs in that cycle; the next cycle is identical to post-power-up.
- Widths: all compares use full SYM_W*SEQ_LEN-bit vectors; the fill counter is $clog2(SEQ_LEN+1) bits.

Decomposition:
- Package seq_det_pkg holds:
  - function clog2
  - a default SYM_W/SEQ_LEN/CNT_W constants set for the board (2/4/8)
- One natural sub-module, seq_hist_shift: SEQ_LEN x SYM_W shift register with fill counter, flush input and equality compare against the pattern vector; outputs hit.
- Top seq_det_param owns pattern load, accept gating, match register and counter.

Test Plan (SYM_W=2, SEQ_LEN=3, CNT_W=2 unless stated):
1. Load pattern 1,2,3; stream 0,1,2,3,0 with in_valid each cycle -> pat_ready=1 after the 3rd pat_wr; match=1 exactly one cycle after in_sym=3 is accepted; match_cnt=1.
2. SEQ_LEN=2, pattern 1,1; stream 1,1,1,1:
   - overlap=1 -> 3 match pulses, match_cnt=3
   - overlap=0 -> 2 pulses, match_cnt=2
3. Pattern 1,2,3; stream 1,2,3 four times, overlap=0 -> 4 pulses; match_cnt saturates at 3; then cnt_clr coinciding with a hit -> match_cnt=0.
4. Load control:
   - 4th pat_wr with pattern full -> ignored, pattern unchanged
   - pat_clr with pat_wr -> pat_cnt=0, pat_ready=0
   - stream 1,2,3 then -> no match
5. Pattern 1,2,3; stream 1,2; det_en=0 for one cycle; then stream 3 -> no match. Stream 1,2 with in_valid gaps between symbols, then 3 -> match.
6. rst pulse after stream 1,2 -> all outputs 0 and pat_ready=0; after reloading 1,2,3, stream 3 alone -> no match.
